// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with valid/ready handshake,
// DEPTH-entry circular buffering, flush and a saturating stall-cycle counter.
// Optional feature macro: PIPE_STAGE_BUF_BYPASS_EN
//   defined   -> an empty buffer forwards in_data to out_data combinationally
//                and passes it through without storing when out_ready=1.
//   undefined -> minimum 1-cycle latency, no combinational in-to-out path.

// Elaboration-time parameter legality check for pipe_stage_buf.
module pipe_stage_buf_param_chk #(
  parameter int DEPTH = 2
) ();
  generate
    if ((DEPTH < 2) || (DEPTH > 16)) begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH=%0d outside legal range 2..16", DEPTH);
    end
  endgenerate
endmodule

module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  pipe_stage_buf_param_chk #(.DEPTH(DEPTH)) u_param_chk ();

  // Pointer advance with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_LAST) begin
      n = PTR_ZERO;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // State registers
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [OCC_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall;

  // Combinational next-state terms
  logic              w_byp;
  logic              w_byp_pass;
  logic              w_out_valid;
  logic              w_push;
  logic              w_store;
  logic              w_deq;
  logic              w_stall_inc;
  logic [PTR_W-1:0]  w_wp_inc;
  logic [PTR_W-1:0]  w_rp_inc;
  logic [PTR_W-1:0]  w_wp_nxt;
  logic [PTR_W-1:0]  w_rp_nxt;
  logic [OCC_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_head_nxt;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
  // An empty buffer exposes the incoming payload in the same cycle.
  assign w_byp = (r_cnt == OCC_ZERO) & in_valid & ~flush & ~rst;
`else
  assign w_byp = 1'b0;
`endif

  assign w_out_valid = r_out_valid | w_byp;
  assign w_byp_pass  = w_byp & out_ready;
  assign w_push      = in_valid & r_in_ready;
  // A bypassed-and-consumed entry never occupies a slot; a flush discards the push.
  assign w_store     = w_push & ~w_byp_pass & ~flush;
  assign w_deq       = r_out_valid & out_ready;
  assign w_wp_inc    = ptr_inc(r_wp);
  assign w_rp_inc    = ptr_inc(r_rp);
  assign w_stall_inc = w_out_valid & ~out_ready & ~flush & (r_stall != STALL_MAX);

  // Next pointers and occupancy from the push/pop handshake, flush overriding.
  always_comb begin
    w_wp_nxt  = r_wp;
    w_rp_nxt  = r_rp;
    w_cnt_nxt = r_cnt;
    if (flush) begin
      w_wp_nxt  = PTR_ZERO;
      w_rp_nxt  = PTR_ZERO;
      w_cnt_nxt = OCC_ZERO;
    end else begin
      if (w_store) begin
        w_wp_nxt = w_wp_inc;
      end else begin
        w_wp_nxt = r_wp;
      end
      if (w_deq) begin
        w_rp_nxt = w_rp_inc;
      end else begin
        w_rp_nxt = r_rp;
      end
      case ({w_store, w_deq})
        2'b10:   w_cnt_nxt = r_cnt + OCC_ONE;
        2'b01:   w_cnt_nxt = r_cnt - OCC_ONE;
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  // Next head-of-queue payload, so out_data comes straight from a register.
  always_comb begin
    w_head_nxt = r_out_data;
    if (flush) begin
      w_head_nxt = r_out_data;
    end else if (w_deq) begin
      if (r_cnt == OCC_ONE) begin
        if (w_store) begin
          w_head_nxt = in_data;
        end else begin
          w_head_nxt = r_out_data;
        end
      end else begin
        w_head_nxt = r_mem[w_rp_inc];
      end
    end else if (w_store && (r_cnt == OCC_ZERO)) begin
      w_head_nxt = in_data;
    end else begin
      w_head_nxt = r_out_data;
    end
  end

  // Control state, head register and stall counter; rst wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= PTR_ZERO;
      r_rp        <= PTR_ZERO;
      r_cnt       <= OCC_ZERO;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_stall     <= {CNT_W{1'b0}};
    end else begin
      r_wp        <= w_wp_nxt;
      r_rp        <= w_rp_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_data  <= w_head_nxt;
      r_out_valid <= (w_cnt_nxt != OCC_ZERO);
      r_in_ready  <= (w_cnt_nxt != OCC_FULL);
      if (w_stall_inc) begin
        r_stall <= r_stall + CNT_W'(1);
      end else begin
        r_stall <= r_stall;
      end
    end
  end

  // Payload storage: cleared on rst, written only on a stored push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_store) begin
      r_mem[r_wp] <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_cnt;
  assign stall_cnt = r_stall;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
  assign out_data = w_byp ? in_data : r_out_data;
`else
  assign out_data = r_out_data;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: three instances (DEPTH 2/4/3, the
// last with a 4-bit stall counter) share one stimulus stream and are each
// compared every cycle against a queue-based reference model.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_data;

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [63:0] od0, od1, od2;
  logic [1:0]  c0;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic [15:0] s0, s1;
  logic [3:0]  s2;

  pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .count(c0), .stall_cnt(s0));
  pipe_stage_buf #(.DATA_W(64), .DEPTH(4), .CNT_W(16)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .count(c1), .stall_cnt(s1));
  pipe_stage_buf #(.DATA_W(64), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .count(c2), .stall_cnt(s2));

  // Reference model: one queue per instance plus stall/reset-data state.
  logic [63:0] mq [3][$];
  int          m_stall [3];
  bit          m_zero  [3];
  bit          e_valid [3];
  bit          e_ready [3];
  bit          e_byp   [3];
  int          depth [3] = '{2, 4, 3};
  int          smax  [3] = '{65535, 65535, 15};
`ifdef PIPE_STAGE_BUF_BYPASS_EN
  bit          byp_en = 1'b1;
`else
  bit          byp_en = 1'b0;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] obs_of(input int i, input int what);
    logic [63:0] r;
    r = 64'd0;
    case (i)
      0: case (what) 0: r = 64'(ir0); 1: r = 64'(ov0); 2: r = od0; 3: r = 64'(c0); default: r = 64'(s0); endcase
      1: case (what) 0: r = 64'(ir1); 1: r = 64'(ov1); 2: r = od1; 3: r = 64'(c1); default: r = 64'(s1); endcase
      default: case (what) 0: r = 64'(ir2); 1: r = 64'(ov2); 2: r = od2; 3: r = 64'(c2); default: r = 64'(s2); endcase
    endcase
    return r;
  endfunction

  // Compare every instance with the model for the current cycle's inputs.
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = mq[i].size();
      e_byp[i]   = byp_en && (sz == 0) && in_valid && !flush && !rst;
      e_valid[i] = (sz != 0) || e_byp[i];
      e_ready[i] = (sz != depth[i]);
      check_val($sformatf("in_ready[d%0d]", depth[i]), obs_of(i, 0), 64'(e_ready[i]));
      check_val($sformatf("out_valid[d%0d]", depth[i]), obs_of(i, 1), 64'(e_valid[i]));
      check_val($sformatf("count[d%0d]", depth[i]), obs_of(i, 3), 64'(sz));
      check_val($sformatf("stall_cnt[d%0d]", depth[i]), obs_of(i, 4), 64'(m_stall[i]));
      if (sz != 0) begin
        check_val($sformatf("out_data[d%0d]", depth[i]), obs_of(i, 2), mq[i][0]);
      end else if (e_byp[i]) begin
        check_val($sformatf("byp_data[d%0d]", depth[i]), obs_of(i, 2), in_data);
      end else if (m_zero[i]) begin
        check_val($sformatf("rst_data[d%0d]", depth[i]), obs_of(i, 2), 64'd0);
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs just sampled.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i].delete();
        m_stall[i] = 0;
        m_zero[i]  = 1'b1;
      end else if (flush) begin
        mq[i].delete();
      end else begin
        if (e_valid[i] && !out_ready && (m_stall[i] < smax[i])) m_stall[i]++;
        if (!(e_byp[i] && out_ready)) begin
          if (e_valid[i] && out_ready) void'(mq[i].pop_front());
          if (in_valid && e_ready[i]) begin
            mq[i].push_back(in_data);
            m_zero[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int v;
    for (int i = 0; i < 3; i++) begin
      m_stall[i] = 0;
      m_zero[i]  = 1'b1;
    end
    // Reset held with a pending push.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hA5; out_ready = 1'b0;
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;
    step();
    flush = 1'b1; in_valid = 1'b0;
    step();
    flush = 1'b0;

    // Streaming with the consumer always ready.
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 64'(k);
      step();
    end
    in_valid = 1'b0;
    step();

    // Back-pressure: consumer stalls, producer holds each value until DEPTH=4 accepts.
    v = 16;
    for (int c = 0; c < 40; c++) begin
      bit acc;
      out_ready = (c >= 8);
      in_valid  = (v <= 21);
      in_data   = 64'(v);
      acc = in_valid && (mq[1].size() < 4);
      step();
      if (acc) v++;
    end
    check_val("bp_all_accepted", 64'(v), 64'd22);

    // Flush while holding entries, with a simultaneous push that must vanish.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 64'h50 + 64'(k);
      step();
    end
    flush = 1'b1; in_data = 64'h99;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_val("flush_count_d4", 64'(c1), 64'd0);
    check_val("flush_valid_d4", 64'(ov1), 64'd0);

    // Pointer wrap: 10 push/pop pairs.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 64'h100 + 64'(k);
      step();
    end
    in_valid = 1'b0;
    step();

    // Stall counter saturation on the 4-bit instance.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check_val("stall_sat_d3", 64'(s2), 64'd15);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();

`ifdef PIPE_STAGE_BUF_BYPASS_EN
    // Zero-latency pass-through on an empty buffer.
    in_valid = 1'b1; in_data = 64'h7; out_ready = 1'b1;
    @(negedge clk);
    check_val("byp_valid_d4", 64'(ov1), 64'd1);
    check_val("byp_data_d4", od1, 64'h7);
    check_val("byp_count_d4", 64'(c1), 64'd0);
    step();
    in_valid = 1'b0;
    step();
`endif

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      in_data   = {$urandom, $urandom};
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
